// File: rtl/rc4_pkg.sv
// Shared types, constants and helpers for the RC4 key-scheduling controller.
// The optional S[i]=i initialisation pass is selected by the KSA_INIT_EN macro.
package rc4_pkg;

  localparam int S_DEPTH   = 256;
  localparam int KEY_BYTES = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_RD_SI,
    ST_WAIT_SI,
    ST_CAP_SI,
    ST_RD_SJ,
    ST_WAIT_SJ,
    ST_CAP_SJ,
    ST_WR_SJ,
    ST_WR_SI,
    ST_DONE
  } ksa_state_t;

  // Key byte 0 is the most significant byte of the key word.
  function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] key,
                                          input logic [1:0]             idx);
    case (idx)
      2'd0:    key_byte = key[23:16];
      2'd1:    key_byte = key[15:8];
      default: key_byte = key[7:0];
    endcase
  endfunction

endpackage

// File: rtl/ksa_swap_seq.sv
// One KSA iteration over the single-port S-memory: read S[i], update j,
// read S[j], then write S[j]=S[i] and S[i]=S[j]. Acks in the final write state.
module ksa_swap_seq
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_go,
  input  logic [7:0] i_i,
  input  logic [7:0] i_j,
  input  logic [7:0] i_kb,
  input  logic [7:0] i_q,
  output logic       o_ack,
  output logic [7:0] o_j,
  output logic [7:0] o_addr_nxt,
  output logic [7:0] o_data_nxt,
  output logic       o_wren_nxt
);

  ksa_state_t r_state;
  ksa_state_t w_state_nxt;
  logic [7:0] r_i;
  logic [7:0] r_j;
  logic [7:0] r_kb;
  logic [7:0] r_si;
  logic [7:0] r_sj;
  logic [7:0] w_j_cap;

  assign w_j_cap = r_j + i_q + r_kb;
  assign o_ack   = (r_state == ST_WR_SI);
  assign o_j     = r_j;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (i_go) w_state_nxt = ST_RD_SI;
      ST_RD_SI:   w_state_nxt = ST_WAIT_SI;
      ST_WAIT_SI: w_state_nxt = ST_CAP_SI;
      ST_CAP_SI:  w_state_nxt = ST_RD_SJ;
      ST_RD_SJ:   w_state_nxt = ST_WAIT_SJ;
      ST_WAIT_SJ: w_state_nxt = ST_CAP_SJ;
      ST_CAP_SJ:  w_state_nxt = ST_WR_SJ;
      ST_WR_SJ:   w_state_nxt = ST_WR_SI;
      ST_WR_SI:   w_state_nxt = i_go ? ST_RD_SI : ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Port values for the state being entered; the parent registers them so the
  // memory sees each address from the first cycle of its state.
  always_comb begin
    o_addr_nxt = r_i;
    o_data_nxt = '0;
    o_wren_nxt = 1'b0;
    case (w_state_nxt)
      ST_RD_SI:  o_addr_nxt = i_i;
      ST_RD_SJ:  o_addr_nxt = w_j_cap;
      ST_WAIT_SJ,
      ST_CAP_SJ: o_addr_nxt = r_j;
      ST_WR_SJ: begin
        o_addr_nxt = r_j;
        o_data_nxt = r_si;
        o_wren_nxt = 1'b1;
      end
      ST_WR_SI: begin
        o_addr_nxt = r_i;
        o_data_nxt = r_sj;
        o_wren_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_kb    <= '0;
      r_si    <= '0;
      r_sj    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_go && (r_state == ST_IDLE || r_state == ST_WR_SI)) begin
        r_i  <= i_i;
        r_j  <= i_j;
        r_kb <= i_kb;
      end
      if (r_state == ST_CAP_SI) begin
        r_si <= i_q;
        r_j  <= w_j_cap;
      end
      if (r_state == ST_CAP_SJ) r_sj <= i_q;
    end
  end

endmodule

// File: rtl/ksa_ctrl.sv
// RC4 key-scheduling controller: owns i/j/key bookkeeping and IDLE/INIT/DONE;
// the per-iteration swap runs in ksa_swap_seq. KSA_INIT_EN adds the S[k]=k pass.
module ksa_ctrl
  import rc4_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] secret_key,
  input  logic [7:0]  q,
  output logic [7:0]  address,
  output logic [7:0]  data,
  output logic        wren,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] I_LAST = 8'(S_DEPTH - 1);

  // ST_RD_SI here stands for the whole swap loop; the sub-states live in u_seq.
  ksa_state_t  r_state;
  ksa_state_t  w_state_nxt;
  logic [7:0]  r_i;
  logic [7:0]  r_j;
  logic [1:0]  r_kidx;
  logic [23:0] r_key;
  logic [7:0]  r_address;
  logic [7:0]  r_data;
  logic        r_wren;
  logic        r_busy;
  logic        r_done;

  logic [7:0]  w_i_nxt;
  logic [7:0]  w_j_nxt;
  logic [1:0]  w_kidx_nxt;
  logic [23:0] w_key_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_go;
  logic [7:0]  w_kb;
  logic [7:0]  w_addr_nxt;
  logic [7:0]  w_data_nxt;
  logic        w_wren_nxt;

  logic        w_seq_ack;
  logic [7:0]  w_seq_j;
  logic [7:0]  w_seq_addr;
  logic [7:0]  w_seq_data;
  logic        w_seq_wren;

  assign w_kb = key_byte(w_key_nxt, w_kidx_nxt);

  ksa_swap_seq u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_go       (w_go),
    .i_i        (w_i_nxt),
    .i_j        (w_j_nxt),
    .i_kb       (w_kb),
    .i_q        (q),
    .o_ack      (w_seq_ack),
    .o_j        (w_seq_j),
    .o_addr_nxt (w_seq_addr),
    .o_data_nxt (w_seq_data),
    .o_wren_nxt (w_seq_wren)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_kidx_nxt  = r_kidx;
    w_key_nxt   = r_key;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_go        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_key_nxt  = secret_key;
          w_i_nxt    = '0;
          w_j_nxt    = '0;
          w_kidx_nxt = '0;
          w_busy_nxt = 1'b1;
`ifdef KSA_INIT_EN
          w_state_nxt = ST_INIT;
`else
          w_state_nxt = ST_RD_SI;
          w_go        = 1'b1;
`endif
        end
      end
`ifdef KSA_INIT_EN
      ST_INIT: begin
        if (r_i == I_LAST) begin
          w_i_nxt     = '0;
          w_state_nxt = ST_RD_SI;
          w_go        = 1'b1;
        end else begin
          w_i_nxt = r_i + 8'd1;
        end
      end
`endif
      ST_RD_SI: begin
        if (w_seq_ack) begin
          w_j_nxt = w_seq_j;
          if (r_i == I_LAST) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_i_nxt    = r_i + 8'd1;
            w_kidx_nxt = (r_kidx == 2'd2) ? 2'd0 : r_kidx + 2'd1;
            w_go       = 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are loaded with the values of the state being entered.
  always_comb begin
    w_addr_nxt = r_address;
    w_data_nxt = r_data;
    w_wren_nxt = 1'b0;
    case (w_state_nxt)
      ST_INIT: begin
        w_addr_nxt = w_i_nxt;
        w_data_nxt = w_i_nxt;
        w_wren_nxt = 1'b1;
      end
      ST_RD_SI: begin
        w_addr_nxt = w_seq_addr;
        w_data_nxt = w_seq_data;
        w_wren_nxt = w_seq_wren;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_kidx    <= '0;
      r_key     <= '0;
      r_address <= '0;
      r_data    <= '0;
      r_wren    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_i       <= w_i_nxt;
      r_j       <= w_j_nxt;
      r_kidx    <= w_kidx_nxt;
      r_key     <= w_key_nxt;
      r_address <= w_addr_nxt;
      r_data    <= w_data_nxt;
      r_wren    <= w_wren_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign address = r_address;
  assign data    = r_data;
  assign wren    = r_wren;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: doc/ksa_ctrl.md
# ksa_ctrl

RC4 key-scheduling controller. It sequences the single-port 256×8 S-memory through the KSA loop: for i = 0..255, j = j + S[i] + key[i mod 3], then swap S[i] and S[j]. It sits between the top-level decrypt FSM, which issues start and waits for done, and the S-memory port. Optionally it also performs the S[i] = i initialisation pass first.

## Interface
- KEY_BYTES, 3: secret key length in bytes. Key byte 0 is secret_key[23:16].
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  level request; sampled only in IDLE.
- secret_key  in  24  key; registered on the accepting edge.
- q  in  8  S-memory read data. Valid on the second edge after the address is driven.
- address  out  8  S-memory address (registered).
- data  out  8  S-memory write data (registered).
- wren  out  1  S-memory write enable (registered).
- busy  out  1  high from the accepting edge until DONE exits.
- done  out  1  one-cycle pulse at completion.

## Operation
- Reset values: address=0, data=0, wren=0, busy=0, done=0; internal i=0, j=0, key register=0; state=IDLE.
- IDLE: if start=1, register the key, clear i and j, and set busy. The next state is INIT (with KSA_INIT_EN) or RD_SI.
- INIT: drive address=i, data=i, wren=1; i increments. After i=255, clear i and go to RD_SI.
- Each KSA iteration takes 8 states:
  - RD_SI: address=i.
  - WAIT_SI: hold the address.
  - CAP_SI: si<=q; j<=j+q+keybyte(i mod 3).
  - RD_SJ: address=j.
  - WAIT_SJ: hold the address.
  - CAP_SJ: sj<=q.
  - WR_SJ: address=j, data=si, wren=1.
  - WR_SI: address=i, data=sj, wren=1.
- From WR_SI: if i=255, go to DONE; otherwise i<=i+1 and go to RD_SI.
- DONE: done=1 and wren=0, then go to IDLE; busy falls on leaving DONE.
- Arithmetic: i and j are 8-bit and wrap modulo 256 with no carry kept. i mod 3 uses a 2-bit counter that wraps 2→0; no divider.
- i==j: both writes target the same address with the same value. The memory is unchanged and the iteration still takes 8 cycles.
- start during busy is ignored. If start is still high in the IDLE cycle after DONE, a new run starts.
- secret_key changes during a run are ignored.
- Reset mid-run: all outputs return to reset values immediately (async). Memory contents are undefined afterwards.
- wren is 0 in every state except INIT, WR_SJ and WR_SI.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Read latency: the address is driven in cycle N, and q is sampled at the end of cycle N+2 (CAP state).
- Run length from the accepting edge to the done cycle:
  - 2048 cycles without KSA_INIT_EN (256 iterations × 8).
  - 2304 cycles with KSA_INIT_EN.
- done is high for exactly 1 cycle; busy is high for run length + 1 cycles.
- Minimum gap between runs: 1 IDLE cycle.

## Configuration
- KSA_INIT_EN defined: the INIT pass runs (256 writes of S[k]=k) before KSA.
- KSA_INIT_EN not defined: the INIT state is removed. The controller requires S-memory to be pre-initialised and starts directly at RD_SI.

## Structure
- Package rc4_pkg holds:
  - state enum ksa_state_t;
  - constants S_DEPTH=256 and KEY_BYTES=3;
  - function key_byte(key, idx) returning an 8-bit slice.
- Sub-module ksa_swap_seq: given i, j_in and a go pulse, it runs the read/read/write/write sequence over the memory port and returns ack. ksa_ctrl keeps the i/j/key bookkeeping and the IDLE/INIT/DONE states.

## Test plan
- Reset: assert rst_n=0 mid-cycle → address=0, data=0, wren=0, busy=0, done=0 immediately; state=IDLE.
- KSA_INIT_EN, key=24'h000000 → INIT writes address k with data k for k=0..255 in consecutive cycles. Iterations i=0,1 are no-op swaps (i==j). At i=2, j=3: WR_SJ writes addr 3 ← 2 and WR_SI writes addr 2 ← 3.
- Full run, key=24'h000249, against a software RC4 KSA model with a 1-cycle-latency memory → final 256-byte S matches the model. done pulses once, exactly 2304 cycles after acceptance.
- start held high throughout → exactly one done per run; the next run begins 1 cycle after DONE. A start pulse during busy causes no extra run.
- rst_n asserted at cycle 100 of a run, then released and start reissued → clean restart with i=0, j=0; done arrives 2304 cycles after the new acceptance.
- secret_key changed at cycle 50 of a run → result matches the key captured at acceptance.
